instr_fetch: RTL

Instruction fetch stage of the 16-bit custom processor, sitting between the 8-bit program counter and the decoder.
- Consumes the PC's current address and issues reads to the synchronous instruction memory.
- Buffers returned 16-bit instructions for the decoder behind a valid/ready handshake.
- Closes the loop back to the PC: drives `pc_select`/`jump_address` for decoded jumps and for replay after buffer overflow.

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues PC reads, buffers returns in a 2-entry FIFO, redirects the PC on jumps/overflow.
// Optional: define IF_JUMP_SQUASH_EN to keep jump instructions out of the FIFO.
module instr_fetch #(
   parameter logic [3:0] JMP_OPCODE    = 4'hF,
   parameter int         FLUSH_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  current_addr,
   output logic        pc_select,
   output logic [7:0]  jump_address,
   output logic        imem_en,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [7:0]  instr_addr,
   input  logic        dec_ready,
   output logic        flushing
);

   localparam int CW = $clog2(FLUSH_TIMEOUT) + 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            pc_select_reg, pc_select_next;
   logic [7:0]      target_reg, target_next;
   logic [7:0]      last_addr_reg;
   logic            last_addr_vld_reg;
   logic            ret_vld_reg;
   logic [7:0]      ret_addr_reg;

   logic [15:0]     fifo_instr_reg [2];
   logic [7:0]      fifo_addr_reg  [2];
   logic            rd_ptr_reg, wr_ptr_reg;
   logic [1:0]      count_reg;

   logic            issue, ret_accept, full, pop, push, is_jump, overflow, jump_take;

   assign ret_accept  = ret_vld_reg && (state_reg == RUN);
   assign full        = (count_reg == 2'd2);
   assign instr_valid = (count_reg != 2'd0);
   assign pop         = instr_valid && dec_ready;
   assign is_jump     = (imem_rdata[15:12] == JMP_OPCODE);
   assign overflow    = ret_accept && full && !pop;
   assign jump_take   = ret_accept && !overflow && is_jump;

`ifdef IF_JUMP_SQUASH_EN
   assign push = ret_accept && !overflow && !is_jump;
`else
   assign push = ret_accept && !overflow;
`endif

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      pc_select_next = 1'b0;
      target_next    = target_reg;
      issue          = 1'b0;
      case (state_reg)
         RUN: begin
            issue = !last_addr_vld_reg || (current_addr != last_addr_reg);
            // Overflow wins: a dropped jump is refetched and decoded again
            if (overflow) begin
               state_next     = FLUSH;
               pc_select_next = 1'b1;
               target_next    = ret_addr_reg;
               cnt_next       = '0;
            end else if (jump_take) begin
               state_next     = FLUSH;
               pc_select_next = 1'b1;
               target_next    = imem_rdata[7:0];
               cnt_next       = '0;
            end
         end
         FLUSH: begin
            if ((cnt_reg >= CW'(2)) && (current_addr == target_reg)) begin
               issue      = 1'b1;
               state_next = RUN;
            end else if (cnt_reg == CW'(FLUSH_TIMEOUT - 1)) begin
               pc_select_next = 1'b1;
               cnt_next       = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Reset must force the read strobe low even though issue is combinational
   assign imem_en      = issue && rstn;
   assign imem_addr    = current_addr;
   assign pc_select    = pc_select_reg;
   assign jump_address = target_reg;
   assign flushing     = (state_reg == FLUSH);
   assign instr        = fifo_instr_reg[rd_ptr_reg];
   assign instr_addr   = fifo_addr_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg         <= RUN;
         cnt_reg           <= '0;
         pc_select_reg     <= 1'b0;
         target_reg        <= '0;
         last_addr_reg     <= '0;
         last_addr_vld_reg <= 1'b0;
         ret_vld_reg       <= 1'b0;
         ret_addr_reg      <= '0;
         rd_ptr_reg        <= 1'b0;
         wr_ptr_reg        <= 1'b0;
         count_reg         <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pc_select_reg <= pc_select_next;
         target_reg    <= target_next;
         ret_vld_reg   <= issue;
         if (issue) begin
            last_addr_reg     <= current_addr;
            last_addr_vld_reg <= 1'b1;
            ret_addr_reg      <= current_addr;
         end
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               fifo_instr_reg[gi] <= '0;
               fifo_addr_reg[gi]  <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               fifo_instr_reg[gi] <= imem_rdata;
               fifo_addr_reg[gi]  <= ret_addr_reg;
            end
         end
      end
   endgenerate

endmodule
